mem_arbiter: RTL and testbench

- Shares the single unified memory port between two requesters: requester 0 is the multicycle CPU core and requester 1 is a host loader/DMA.
- Each requester issues one word transaction at a time using a req/gnt/done handshake.
- The arbiter latches the winning request, drives the memory for exactly one cycle, and waits a fixed read latency. It then returns the read data and signals completion.
- It sits between the CPU top level and the memory model, in place of a direct core-to-memory connection.

---
 rtl/mem_arb_pkg.sv | 7 +
 rtl/mem_arb_rr_pick2.sv | 13 +
 rtl/mem_arbiter.sv | 111 +++++++++++
 tb/tb_mem_arbiter.sv | 292 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: shared types and constants for the two-requester memory arbiter.
package mem_arb_pkg;
    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} arb_state_t;
    localparam int AW_DEF = 32;
    localparam int DW_DEF = 32;
    localparam int CNT_W = 3;
endpackage

// File: rtl/mem_arb_rr_pick2.sv
// rr_pick2: combinational two-way picker, round-robin or fixed priority to requester 0.
module rr_pick2 (
    input  logic [1:0] req,
    input  logic       rr,
    input  logic       prio_fixed,
    output logic       valid,
    output logic       winner
);
    always_comb begin
        valid = |req;
        winner = &req ? (~prio_fixed & rr) : req[1];
    end
endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one memory port between the CPU core (r0) and a host loader (r1).
// One word transaction at a time; reads wait a fixed RD_LAT before completing.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int AW           = AW_DEF,
    parameter int DW           = DW_DEF,
    parameter int RD_LAT       = 1,
    parameter bit CPU_PRIORITY = 1'b0
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          r0_req,
    input  logic          r0_we,
    input  logic [AW-1:0] r0_adr,
    input  logic [DW-1:0] r0_wd,
    output logic          r0_gnt,
    output logic          r0_done,
    input  logic          r1_req,
    input  logic          r1_we,
    input  logic [AW-1:0] r1_adr,
    input  logic [DW-1:0] r1_wd,
    output logic          r1_gnt,
    output logic          r1_done,
    output logic [DW-1:0] rdata,
    output logic          mem_en,
    output logic          mem_we,
    output logic [AW-1:0] mem_adr,
    output logic [DW-1:0] mem_wd,
    input  logic [DW-1:0] mem_rd,
    output logic          busy
);
    arb_state_t       state_q;
    logic             rr_q, win_q, mem_en_q, mem_we_q;
    logic [1:0]       gnt_q, done_q;
    logic [CNT_W-1:0] cnt_q;
    logic [AW-1:0]    mem_adr_q;
    logic [DW-1:0]    mem_wd_q, rdata_q;
    logic             valid, winner;

    rr_pick2 u_pick (
        .req       ({r1_req, r0_req}),
        .rr        (rr_q),
        .prio_fixed(CPU_PRIORITY),
        .valid     (valid),
        .winner    (winner)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            rr_q      <= 1'b0;
            win_q     <= 1'b0;
            gnt_q     <= '0;
            done_q    <= '0;
            cnt_q     <= '0;
            mem_en_q  <= 1'b0;
            mem_we_q  <= 1'b0;
            mem_adr_q <= '0;
            mem_wd_q  <= '0;
            rdata_q   <= '0;
        end else begin
            gnt_q    <= '0;
            done_q   <= '0;
            mem_en_q <= 1'b0;
            mem_we_q <= 1'b0;
            case (state_q)
                IDLE: if (valid) begin
                    state_q       <= ISSUE;
                    win_q         <= winner;
                    gnt_q[winner] <= 1'b1;
                    mem_en_q      <= 1'b1;
                    mem_we_q      <= winner ? r1_we : r0_we;
                    mem_adr_q     <= winner ? r1_adr : r0_adr;
                    mem_wd_q      <= winner ? r1_wd : r0_wd;
                end
                // mem_we_q still holds the latched direction during ISSUE
                ISSUE: if (mem_we_q) begin
                    state_q       <= DONE;
                    done_q[win_q] <= 1'b1;
                end else begin
                    cnt_q   <= CNT_W'(RD_LAT - 1);
                    state_q <= WAIT;
                end
                WAIT: if (cnt_q == '0) begin
                    rdata_q       <= mem_rd;
                    done_q[win_q] <= 1'b1;
                    state_q       <= DONE;
                end else begin
                    cnt_q <= cnt_q - 1'b1;
                end
                DONE: begin
                    if (!CPU_PRIORITY) rr_q <= ~win_q;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign r0_gnt  = gnt_q[0];
    assign r1_gnt  = gnt_q[1];
    assign r0_done = done_q[0];
    assign r1_done = done_q[1];
    assign mem_en  = mem_en_q;
    assign mem_we  = mem_we_q;
    assign mem_adr = mem_adr_q;
    assign mem_wd  = mem_wd_q;
    assign rdata   = rdata_q;
    assign busy    = state_q != IDLE;
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed checks on three arbiter configurations sharing one clock and reset.
module tb_mem_arbiter;
    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    // instance 0: RD_LAT=1 rr, instance 1: RD_LAT=3 rr, instance 2: RD_LAT=4 fixed priority
    localparam logic [8:0] LATS = {3'd4, 3'd3, 3'd1};
    localparam logic [2:0] PRIS = 3'b100;

    logic        r0_req [3], r0_we [3], r1_req [3], r1_we [3];
    logic [31:0] r0_adr [3], r0_wd [3], r1_adr [3], r1_wd [3];
    logic        r0_gnt [3], r0_done [3], r1_gnt [3], r1_done [3];
    logic        mem_en [3], mem_we [3], busy [3];
    logic [31:0] rdata [3], mem_adr [3], mem_wd [3], rd_val [3];
    int vec = 0;
    int errs = 0;

    for (genvar g = 0; g < 3; g++) begin : gen_dut
        localparam int LAT = int'(LATS[3*g +: 3]);
        logic [7:0]  en_sh;
        logic [31:0] mrd;
        mem_arbiter #(.AW(32), .DW(32), .RD_LAT(LAT), .CPU_PRIORITY(PRIS[g])) u_dut (
            .clk(clk), .reset(reset),
            .r0_req(r0_req[g]), .r0_we(r0_we[g]), .r0_adr(r0_adr[g]), .r0_wd(r0_wd[g]),
            .r0_gnt(r0_gnt[g]), .r0_done(r0_done[g]),
            .r1_req(r1_req[g]), .r1_we(r1_we[g]), .r1_adr(r1_adr[g]), .r1_wd(r1_wd[g]),
            .r1_gnt(r1_gnt[g]), .r1_done(r1_done[g]),
            .rdata(rdata[g]), .mem_en(mem_en[g]), .mem_we(mem_we[g]),
            .mem_adr(mem_adr[g]), .mem_wd(mem_wd[g]), .mem_rd(mrd), .busy(busy[g])
        );
        // memory model: read data is only valid exactly LAT cycles after the strobe
        always @(posedge clk) en_sh <= reset ? 8'h0 : {en_sh[6:0], mem_en[g]};
        assign mrd = en_sh[LAT-1] ? rd_val[g] : 32'hBAD0_BAD0;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (2) tick();
        for (int g = 0; g < 3; g++) begin
            vec++;
            if ({busy[g], r0_gnt[g], r1_gnt[g], r0_done[g], r1_done[g], mem_en[g], mem_we[g],
                 mem_adr[g], mem_wd[g], rdata[g]} !== '0) begin
                errs++;
                $display("FAIL reset_state inst %0d: busy=%b gnt=%b%b done=%b%b en=%b we=%b adr=%h wd=%h rdata=%h, required all 0",
                         g, busy[g], r1_gnt[g], r0_gnt[g], r1_done[g], r0_done[g], mem_en[g], mem_we[g],
                         mem_adr[g], mem_wd[g], rdata[g]);
            end
        end
        reset = 1'b0;
        tick();
    endtask

    task automatic test_rr();
        int n = 0;
        logic last_en = 1'b0;
        logic last_w = 1'b0;
        bit fin = 1'b0;
        r0_req[0] = 1'b1; r0_we[0] = 1'b1; r0_adr[0] = 32'h100; r0_wd[0] = 32'h1111;
        r1_req[0] = 1'b1; r1_we[0] = 1'b1; r1_adr[0] = 32'h200; r1_wd[0] = 32'h2222;
        for (int c = 0; c < 40 && !fin; c++) begin
            tick();
            vec++;
            if ((mem_en[0] && last_en) || (r0_gnt[0] && r1_gnt[0])) begin
                errs++;
                $display("FAIL rr_overlap: mem_en=%b prev=%b gnt0=%b gnt1=%b, required no back-to-back strobe or double grant",
                         mem_en[0], last_en, r0_gnt[0], r1_gnt[0]);
            end
            last_en = mem_en[0];
            if (r0_gnt[0] || r1_gnt[0]) begin
                last_w = r1_gnt[0];
                vec++;
                if (last_w !== n[0] || mem_adr[0] !== (n[0] ? 32'h200 : 32'h100)) begin
                    errs++;
                    $display("FAIL rr_order grant %0d: winner=%0d adr=%h, required winner=%0d adr=%h",
                             n, last_w, mem_adr[0], n[0], n[0] ? 32'h200 : 32'h100);
                end
                n++;
            end
            if (r0_done[0] || r1_done[0]) begin
                vec++;
                if (r1_done[0] !== last_w || (r0_done[0] && r1_done[0])) begin
                    errs++;
                    $display("FAIL rr_done: done0=%b done1=%b, required done only for winner %0d",
                             r0_done[0], r1_done[0], last_w);
                end
                if (n == 4) begin
                    r0_req[0] = 1'b0;
                    r1_req[0] = 1'b0;
                    fin = 1'b1;
                end
            end
        end
        vec++;
        if (!fin) begin
            errs++;
            $display("FAIL rr_timeout: grants=%0d, required 4 completed", n);
        end
        tick();
    endtask

    task automatic test_write();
        r0_req[0] = 1'b1; r0_we[0] = 1'b1; r0_adr[0] = 32'h40; r0_wd[0] = 32'hDEAD_BEEF;
        tick();
        vec++;
        if ({mem_en[0], mem_we[0], r0_gnt[0], r1_gnt[0], busy[0]} !== 5'b11101 ||
            mem_adr[0] !== 32'h40 || mem_wd[0] !== 32'hDEAD_BEEF) begin
            errs++;
            $display("FAIL write_issue: en=%b we=%b gnt0=%b gnt1=%b busy=%b adr=%h wd=%h, required 1 1 1 0 1 00000040 deadbeef",
                     mem_en[0], mem_we[0], r0_gnt[0], r1_gnt[0], busy[0], mem_adr[0], mem_wd[0]);
        end
        tick();
        vec++;
        if ({r0_done[0], r1_done[0], mem_en[0], mem_we[0], r0_gnt[0]} !== 5'b10000 || rdata[0] !== 32'h0) begin
            errs++;
            $display("FAIL write_done: done0=%b done1=%b en=%b we=%b gnt0=%b rdata=%h, required 1 0 0 0 0 rdata 00000000",
                     r0_done[0], r1_done[0], mem_en[0], mem_we[0], r0_gnt[0], rdata[0]);
        end
        r0_req[0] = 1'b0;
        tick();
        vec++;
        if (busy[0] !== 1'b0 || r0_done[0] !== 1'b0) begin
            errs++;
            $display("FAIL write_idle: busy=%b done0=%b, required 0 0", busy[0], r0_done[0]);
        end
    endtask

    task automatic test_read();
        rd_val[1] = 32'h1234_5678;
        r1_req[1] = 1'b1; r1_we[1] = 1'b0; r1_adr[1] = 32'h80;
        tick();
        vec++;
        if ({r1_gnt[1], r0_gnt[1], mem_en[1], mem_we[1]} !== 4'b1010 || mem_adr[1] !== 32'h80) begin
            errs++;
            $display("FAIL read_issue: gnt1=%b gnt0=%b en=%b we=%b adr=%h, required 1 0 1 0 00000080",
                     r1_gnt[1], r0_gnt[1], mem_en[1], mem_we[1], mem_adr[1]);
        end
        for (int c = 2; c <= 6; c++) begin
            tick();
            vec++;
            if (r1_done[1] !== 1'(c == 5) || busy[1] !== 1'(c <= 5) || mem_en[1] !== 1'b0) begin
                errs++;
                $display("FAIL read_cycle%0d: done1=%b busy=%b en=%b, required %b %b 0",
                         c, r1_done[1], busy[1], mem_en[1], c == 5, c <= 5);
            end
            if (c == 5) begin
                vec++;
                if (rdata[1] !== 32'h1234_5678) begin
                    errs++;
                    $display("FAIL read_data: rdata=%h, required 12345678", rdata[1]);
                end
                r1_req[1] = 1'b0;
            end
        end
    endtask

    task automatic test_stability();
        rd_val[1] = 32'h5555_AAAA;
        r0_req[1] = 1'b1; r0_we[1] = 1'b0; r0_adr[1] = 32'h10;
        tick();
        vec++;
        if (r0_gnt[1] !== 1'b1 || mem_adr[1] !== 32'h10) begin
            errs++;
            $display("FAIL stab_issue: gnt0=%b adr=%h, required 1 00000010", r0_gnt[1], mem_adr[1]);
        end
        for (int c = 2; c <= 5; c++) begin
            tick();
            if (c == 2) r0_adr[1] = 32'h20;
            vec++;
            if (mem_adr[1] !== 32'h10 || r0_done[1] !== 1'(c == 5)) begin
                errs++;
                $display("FAIL stab_cycle%0d: adr=%h done0=%b, required 00000010 %b", c, mem_adr[1], r0_done[1], c == 5);
            end
            if (c == 5) begin
                vec++;
                if (rdata[1] !== 32'h5555_AAAA) begin
                    errs++;
                    $display("FAIL stab_data: rdata=%h, required 5555aaaa", rdata[1]);
                end
                r0_req[1] = 1'b0;
            end
        end
        tick();
    endtask

    task automatic test_prio();
        int n0 = 0;
        bit fin = 1'b0;
        r0_req[2] = 1'b1; r0_we[2] = 1'b1; r0_adr[2] = 32'h300; r0_wd[2] = 32'h3;
        r1_req[2] = 1'b1; r1_we[2] = 1'b1; r1_adr[2] = 32'h400; r1_wd[2] = 32'h4;
        for (int c = 0; c < 60 && !fin; c++) begin
            tick();
            if (r0_gnt[2] || r1_gnt[2]) begin
                vec++;
                if (r1_gnt[2] !== 1'(n0 >= 3) || r0_gnt[2] === r1_gnt[2]) begin
                    errs++;
                    $display("FAIL prio_grant after %0d r0 grants: gnt0=%b gnt1=%b, required winner %0d",
                             n0, r0_gnt[2], r1_gnt[2], n0 >= 3);
                end
                if (r0_gnt[2]) n0++;
            end
            if (r0_done[2] && n0 == 3) r0_req[2] = 1'b0;
            if (r1_done[2]) begin
                r1_req[2] = 1'b0;
                fin = 1'b1;
            end
        end
        vec++;
        if (!fin || n0 != 3) begin
            errs++;
            $display("FAIL prio_timeout: r0 grants=%0d r1 done=%0d, required 3 and 1", n0, fin);
        end
        tick();
    endtask

    task automatic test_reset_wait();
        rd_val[2] = 32'hCAFE_F00D;
        r0_req[2] = 1'b1; r0_we[2] = 1'b0; r0_adr[2] = 32'h30;
        tick();
        vec++;
        if (r0_gnt[2] !== 1'b1) begin
            errs++;
            $display("FAIL rstw_issue: gnt0=%b, required 1", r0_gnt[2]);
        end
        repeat (2) tick();
        reset = 1'b1;
        r0_req[2] = 1'b0;
        tick();
        vec++;
        if ({busy[2], r0_gnt[2], r1_gnt[2], r0_done[2], r1_done[2], mem_en[2], mem_we[2],
             mem_adr[2], mem_wd[2], rdata[2]} !== '0) begin
            errs++;
            $display("FAIL rstw_state: busy=%b done0=%b en=%b adr=%h rdata=%h, required all 0",
                     busy[2], r0_done[2], mem_en[2], mem_adr[2], rdata[2]);
        end
        reset = 1'b0;
        for (int c = 0; c < 8; c++) begin
            tick();
            vec++;
            if (r0_done[2] || r1_done[2] || busy[2]) begin
                errs++;
                $display("FAIL rstw_quiet: done0=%b done1=%b busy=%b, required 0 0 0", r0_done[2], r1_done[2], busy[2]);
            end
        end
        r1_req[2] = 1'b1; r1_we[2] = 1'b0; r1_adr[2] = 32'h44;
        tick();
        vec++;
        if (r1_gnt[2] !== 1'b1 || mem_adr[2] !== 32'h44) begin
            errs++;
            $display("FAIL rstw_r1_issue: gnt1=%b adr=%h, required 1 00000044", r1_gnt[2], mem_adr[2]);
        end
        for (int c = 2; c <= 6; c++) begin
            tick();
            vec++;
            if (r1_done[2] !== 1'(c == 6) || r0_done[2] !== 1'b0) begin
                errs++;
                $display("FAIL rstw_r1_cycle%0d: done1=%b done0=%b, required %b 0", c, r1_done[2], r0_done[2], c == 6);
            end
            if (c == 6) begin
                vec++;
                if (rdata[2] !== 32'hCAFE_F00D) begin
                    errs++;
                    $display("FAIL rstw_r1_data: rdata=%h, required cafef00d", rdata[2]);
                end
                r1_req[2] = 1'b0;
            end
        end
        tick();
    endtask

    initial begin
        for (int g = 0; g < 3; g++) begin
            r0_req[g] = 1'b0; r0_we[g] = 1'b0; r0_adr[g] = '0; r0_wd[g] = '0;
            r1_req[g] = 1'b0; r1_we[g] = 1'b0; r1_adr[g] = '0; r1_wd[g] = '0;
            rd_val[g] = '0;
        end
        test_reset();
        test_rr();
        test_write();
        test_read();
        test_stability();
        test_prio();
        test_reset_wait();
        $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
        $finish;
    end
endmodule
